// File: rtl/apb_ram_param.sv
// Parametrised APB4 slave RAM with byte strobes, configurable wait states,
// alignment / range checking and a write-protected low region.
// Storage is flop-based and async-cleared, so it never maps to a RAM macro.
module apb_ram_param #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned RO_WORDS    = 0
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic [DATA_W-1:0]     pwdata,
   input  logic [DATA_W/8-1:0]   pstrb,
   output logic [DATA_W-1:0]     prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int unsigned NB  = DATA_W / 8;
   localparam int unsigned LSB = $clog2(NB);
   localparam int unsigned AW  = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic [ADDR_W-1:0]   widx;
   logic [AW-1:0]       idx;
   logic                misaligned, out_of_range, prot, err;

   assign widx = paddr >> LSB;
   assign idx  = widx[AW-1:0];
   // Full upper-address compare so aliased addresses above DEPTH are rejected.
   assign out_of_range = (widx >= ADDR_W'(DEPTH));

   if (LSB > 0) begin : gen_align
      assign misaligned = |paddr[LSB-1:0];
   end else begin : gen_no_align
      assign misaligned = 1'b0;
   end

   if (RO_WORDS > 0) begin : gen_prot
      assign prot = pwrite && (widx < ADDR_W'(RO_WORDS));
   end else begin : gen_no_prot
      assign prot = 1'b0;
   end

   assign err = misaligned | out_of_range | prot;

   // Next-state logic: transfer FSM, response registers and memory update.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      mem_d     = mem_q;
      unique case (state_q)
         StIdle: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            if (psel && !penable) begin
               cnt_d   = 4'(WAIT_STATES);
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (!psel) begin
               // Master abandoned the transfer: no commit, no response.
               state_d = StIdle;
            end else if (penable) begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  pready_d  = 1'b1;
                  pslverr_d = err;
                  state_d   = StDone;
                  if (!pwrite) begin
                     prdata_d = err ? '0 : mem_q[idx];
                  end else if (!err) begin
                     for (int i = 0; i < NB; i++) begin
                        if (pstrb[i]) begin
                           mem_d[idx][8*i +: 8] = pwdata[8*i +: 8];
                        end
                     end
                  end
               end
            end
         end
         StDone: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and storage registers, cleared asynchronously by preset.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram_param.sv
// Scoreboard bench for apb_ram_param (32-bit, 32 words, 2 wait states,
// words 0..3 write-protected).
module tb_apb_ram_param;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0]  pstrb;
   logic        pready, pslverr;

   typedef struct {
      logic        is_rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [32];
   int          n_checks = 0;
   int          n_pass   = 0;

   apb_ram_param #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .DEPTH       (32),
      .WAIT_STATES (2),
      .RO_WORDS    (4)
   ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Completes one transfer; returns at the negedge of the pready cycle so a
   // following call issues its setup phase back-to-back.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
      int cyc;
      bit done;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = addr; pwdata = data; pstrb = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge pclk);
         cyc++;
         if (pready) done = 1'b1;
      end
      check("latency", 64'(cyc), 64'd4);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input logic exp_err);
      exp_t e;
      e.is_rd = 1'b0; e.data = '0; e.err = exp_err;
      sb.push_back(e);
      if (!exp_err) begin
         for (int i = 0; i < 4; i++)
            if (strb[i]) mdl[addr[6:2]][8*i +: 8] = data[8*i +: 8];
      end
      xfer(1'b1, addr, data, strb);
   endtask

   task automatic rd(input logic [31:0] addr, input logic exp_err);
      exp_t e;
      e.is_rd = 1'b1; e.err = exp_err;
      e.data  = exp_err ? 32'h0 : mdl[addr[6:2]];
      sb.push_back(e);
      xfer(1'b0, addr, 32'h0, 4'h0);
   endtask

   task automatic go_idle();
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // Compare every completed transfer against the oldest expectation.
   always @(negedge pclk) begin
      if (pready) begin
         if (sb.size() == 0) begin
            check("unexpected_pready", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pslverr", 64'(pslverr), 64'(e.err));
            if (e.is_rd) check("prdata", 64'(prdata), 64'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      #23;
      check("rst_pready", 64'(pready), 64'd0);
      check("rst_pslverr", 64'(pslverr), 64'd0);
      check("rst_prdata", 64'(prdata), 64'd0);
      @(negedge pclk); preset = 1'b0;

      // 1. full write then back-to-back read
      wr(32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
      rd(32'h40, 1'b0);
      // 2. partial strobes and an empty strobe
      wr(32'h40, 32'h11223344, 4'b0101, 1'b0);
      rd(32'h40, 1'b0);
      wr(32'h40, 32'h55667788, 4'b0000, 1'b0);
      rd(32'h40, 1'b0);
      // 3. out-of-range read and write, then sweep all words
      rd(32'h80, 1'b1);
      wr(32'h80, 32'hFFFFFFFF, 4'hF, 1'b1);
      wr(32'h1000_0000, 32'hFFFFFFFF, 4'hF, 1'b1);
      for (int w = 0; w < 32; w++) rd(32'(w * 4), 1'b0);
      // 4. misaligned write, protected write, protected read is allowed
      wr(32'h42, 32'h0BADF00D, 4'hF, 1'b1);
      rd(32'h40, 1'b0);
      wr(32'h04, 32'hA5A5A5A5, 4'hF, 1'b1);
      rd(32'h04, 1'b0);
      rd(32'h43, 1'b1);
      wr(32'h10, 32'h01020304, 4'hF, 1'b0);
      rd(32'h10, 1'b0);
      go_idle();

      // 5. reset in the second wait cycle of a write
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h44; pwdata = 32'h12345678; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1;
      #1;
      check("async_rst_pready", 64'(pready), 64'd0);
      check("async_rst_pslverr", 64'(pslverr), 64'd0);
      check("async_rst_prdata", 64'(prdata), 64'd0);
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk); preset = 1'b0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      rd(32'h44, 1'b0);
      rd(32'h40, 1'b0);
      rd(32'h10, 1'b0);
      go_idle();

      // 6. psel dropped during wait cycles aborts the write
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h48; pwdata = 32'h87654321; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge pclk);
         check("abort_no_pready", 64'(pready), 64'd0);
      end
      rd(32'h48, 1'b0);
      wr(32'h48, 32'hCAFEF00D, 4'hF, 1'b0);
      rd(32'h48, 1'b0);
      go_idle();

      repeat (4) @(posedge pclk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
